// File: rtl/loteria_multi_if.sv
// rtl/loteria_multi_if.sv - player-side bus of the Loteria scorer
// master: drives numero/insere/fim/fim_jogo, observes status and results
// slave : the scorer; receives the controls, drives aceita, jogador, premio,
//         premio_valid, pontos, vencedor, empate, game_over
interface loteria_multi_if #(
  parameter int NUM_W     = 4,
  parameter int N_PLAYERS = 2,
  parameter int SCORE_W   = 5
);
  localparam int PW = $clog2(N_PLAYERS) + 1;

  logic [NUM_W-1:0]             numero;
  logic                         insere;
  logic                         fim;
  logic                         fim_jogo;
  logic                         aceita;
  logic [PW-1:0]                jogador;
  logic [2:0]                   premio;
  logic                         premio_valid;
  logic [N_PLAYERS*SCORE_W-1:0] pontos;
  logic [PW-1:0]                vencedor;
  logic                         empate;
  logic                         game_over;

  modport master (
    output numero, insere, fim, fim_jogo,
    input  aceita, jogador, premio, premio_valid, pontos, vencedor, empate, game_over
  );

  modport slave (
    input  numero, insere, fim, fim_jogo,
    output aceita, jogador, premio, premio_valid, pontos, vencedor, empate, game_over
  );
endinterface

// File: rtl/loteria_multi.sv
// rtl/loteria_multi.sv - multi-player lottery scorer with saturating scores
// clock : rising-edge system clock
// reset : asynchronous active-low, clears all state
// bus   : loteria_multi_if slave (draw/bet entry, prize, scores, winner)
module loteria_multi #(
  parameter int NUM_W     = 4,
  parameter int BET_LEN   = 5,
  parameter int N_PLAYERS = 2,
  parameter int SCORE_W   = 5
) (
  input  logic               clock,
  input  logic               reset,
  loteria_multi_if.slave     bus
);
  localparam int PW = $clog2(N_PLAYERS) + 1;
  localparam int CW = $clog2(BET_LEN + 1);
  localparam logic [SCORE_W+3:0] SCORE_MAX = (SCORE_W+4)'((1 << SCORE_W) - 1);

  typedef enum logic [1:0] {S_DRAW, S_BET, S_EVAL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      jog_q, jog_d;
  logic [NUM_W-1:0]   draw_q [BET_LEN];
  logic [NUM_W-1:0]   draw_d [BET_LEN];
  logic [NUM_W-1:0]   bet_q  [BET_LEN];
  logic [NUM_W-1:0]   bet_d  [BET_LEN];
  logic [BET_LEN-1:0] val_q, val_d;
  logic [2:0]         premio_q, premio_d;
  logic [SCORE_W-1:0] score_q [N_PLAYERS];
  logic [SCORE_W-1:0] score_d [N_PLAYERS];

  logic [CW-1:0]      hits, run, run_max;
  logic [2:0]         cat;
  logic [3:0]         pts;
  logic               aceita;

  // Prize classification of the bet currently held; only consumed in S_EVAL.
  always_comb begin
    hits    = '0;
    run     = '0;
    run_max = '0;
    for (int i = 0; i < BET_LEN; i++) begin
      if (val_q[i] && bet_q[i] == draw_q[i]) begin
        hits = hits + 1'b1;
        run  = run + 1'b1;
        if (run > run_max) run_max = run;
      end else begin
        run = '0;
      end
    end
    if (hits == CW'(BET_LEN))     cat = 3'd5;
    else if (run_max >= CW'(3))   cat = 3'd4;
    else if (hits >= CW'(3))      cat = 3'd3;
    else                          cat = 3'(hits);
    case (cat)
      3'd1:    pts = 4'd1;
      3'd2:    pts = 4'd2;
      3'd3:    pts = 4'd4;
      3'd4:    pts = 4'd6;
      3'd5:    pts = 4'd10;
      default: pts = 4'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    jog_d    = jog_q;
    draw_d   = draw_q;
    bet_d    = bet_q;
    val_d    = val_q;
    premio_d = premio_q;
    score_d  = score_q;
    aceita   = 1'b0;
    case (state_q)
      S_DRAW: begin
        aceita = 1'b1;
        if (bus.fim_jogo) begin
          state_d = S_DONE;
        end else if (bus.insere) begin
          for (int i = 0; i < BET_LEN; i++)
            if (cnt_q == CW'(i)) draw_d[i] = bus.numero;
          if (cnt_q == CW'(BET_LEN - 1)) begin
            cnt_d   = '0;
            state_d = S_BET;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_BET: begin
        aceita = (cnt_q < CW'(BET_LEN));
        if (bus.fim_jogo) begin
          state_d = S_DONE;
        end else begin
          // A number arriving with fim is stored before the bet closes.
          if (bus.insere && aceita) begin
            for (int i = 0; i < BET_LEN; i++)
              if (cnt_q == CW'(i)) begin
                bet_d[i] = bus.numero;
                val_d[i] = 1'b1;
              end
            cnt_d = cnt_q + 1'b1;
          end
          if (bus.fim) state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        premio_d = cat;
        for (int k = 0; k < N_PLAYERS; k++)
          if (jog_q == PW'(k)) begin
            logic [SCORE_W+3:0] sum;
            sum = (SCORE_W+4)'(score_q[k]) + (SCORE_W+4)'(pts);
            score_d[k] = (sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : sum[SCORE_W-1:0];
          end
        jog_d   = (jog_q == PW'(N_PLAYERS - 1)) ? '0 : jog_q + 1'b1;
        cnt_d   = '0;
        val_d   = '0;
        state_d = S_BET;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_DRAW;
      cnt_q    <= '0;
      jog_q    <= '0;
      val_q    <= '0;
      premio_q <= '0;
      for (int i = 0; i < BET_LEN; i++) begin
        draw_q[i] <= '0;
        bet_q[i]  <= '0;
      end
      for (int k = 0; k < N_PLAYERS; k++) score_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      jog_q    <= jog_d;
      val_q    <= val_d;
      premio_q <= premio_d;
      draw_q   <= draw_d;
      bet_q    <= bet_d;
      score_q  <= score_d;
    end
  end

  // Winner search: strictly greater keeps the lowest index, equality flags a tie.
  logic [SCORE_W-1:0] best;
  logic [PW-1:0]      best_idx;
  logic               tie;
  always_comb begin
    best     = score_q[0];
    best_idx = '0;
    tie      = 1'b0;
    for (int k = 1; k < N_PLAYERS; k++) begin
      if (score_q[k] > best) begin
        best     = score_q[k];
        best_idx = PW'(k);
        tie      = 1'b0;
      end else if (score_q[k] == best) begin
        tie = 1'b1;
      end
    end
  end

  always_comb begin
    bus.pontos = '0;
    for (int k = 0; k < N_PLAYERS; k++)
      bus.pontos[k*SCORE_W +: SCORE_W] = score_q[k];
  end

  assign bus.aceita       = aceita;
  assign bus.jogador      = jog_q;
  assign bus.premio       = (state_q == S_EVAL) ? cat : premio_q;
  assign bus.premio_valid = (state_q == S_EVAL);
  assign bus.game_over    = (state_q == S_DONE);
  assign bus.vencedor     = (state_q == S_DONE) ? best_idx : '0;
  assign bus.empate       = (state_q == S_DONE) && tie;
endmodule

// File: tb/tb_loteria_multi.sv
// tb/tb_loteria_multi.sv - self-checking bench for loteria_multi
module tb_loteria_multi;
  localparam int NP = 2;
  localparam int BL = 5;
  localparam int SW = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  loteria_multi_if #(.NUM_W(4), .N_PLAYERS(NP), .SCORE_W(SW)) bus ();

  loteria_multi #(.NUM_W(4), .BET_LEN(BL), .N_PLAYERS(NP), .SCORE_W(SW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: draw and bet as plain lists, scores as integers.
  localparam int PH_DRAW = 0, PH_BET = 1, PH_EVAL = 2, PH_DONE = 3;
  int m_draw[$];
  int m_bet[$];
  int m_score[NP];
  int m_jog;
  int m_phase;
  int m_premio;
  int pts_tab[6] = '{0, 1, 2, 4, 6, 10};

  function automatic int classify();
    int h = 0, r = 0, rmax = 0;
    for (int i = 0; i < BL; i++) begin
      if (i < m_bet.size() && m_bet[i] == m_draw[i]) begin
        h++; r++;
        if (r > rmax) rmax = r;
      end else r = 0;
    end
    if (h == BL) return 5;
    if (rmax >= 3) return 4;
    if (h >= 3) return 3;
    return h;
  endfunction

  task automatic model_reset();
    m_draw.delete(); m_bet.delete();
    foreach (m_score[k]) m_score[k] = 0;
    m_jog = 0; m_phase = PH_DRAW; m_premio = 0;
  endtask

  task automatic model_step(input bit ins, input int n, input bit f, input bit fj);
    case (m_phase)
      PH_DRAW: if (fj) m_phase = PH_DONE;
               else if (ins) begin
                 m_draw.push_back(n);
                 if (m_draw.size() == BL) m_phase = PH_BET;
               end
      PH_BET:  if (fj) m_phase = PH_DONE;
               else begin
                 if (ins && m_bet.size() < BL) m_bet.push_back(n);
                 if (f) begin
                   m_phase  = PH_EVAL;
                   m_premio = classify();
                 end
               end
      PH_EVAL: begin
                 m_score[m_jog] = m_score[m_jog] + pts_tab[m_premio];
                 if (m_score[m_jog] > (1 << SW) - 1) m_score[m_jog] = (1 << SW) - 1;
                 m_jog = (m_jog + 1) % NP;
                 m_bet.delete();
                 m_phase = PH_BET;
               end
      default: ;
    endcase
  endtask

  function automatic int score_of(input int k);
    return int'(bus.pontos[k*SW +: SW]);
  endfunction

  always @(negedge clock) begin
    if (chk_en && reset) begin
      int best, widx, nbest;
      best = -1; widx = 0; nbest = 0;
      foreach (m_score[k]) begin
        if (m_score[k] > best) begin best = m_score[k]; widx = k; nbest = 1; end
        else if (m_score[k] == best) nbest++;
      end
      check("aceita", bus.aceita,
            (m_phase == PH_DRAW) || (m_phase == PH_BET && m_bet.size() < BL));
      check("jogador", bus.jogador, m_jog);
      check("premio_valid", bus.premio_valid, m_phase == PH_EVAL);
      check("premio", bus.premio, m_premio);
      for (int k = 0; k < NP; k++) check($sformatf("pontos[%0d]", k), score_of(k), m_score[k]);
      check("game_over", bus.game_over, m_phase == PH_DONE);
      check("vencedor", bus.vencedor, (m_phase == PH_DONE) ? widx : 0);
      check("empate", bus.empate, (m_phase == PH_DONE) && nbest > 1);
    end
  end

  task automatic cyc(input bit ins, input int n, input bit f, input bit fj);
    bus.insere = ins; bus.numero = 4'(n); bus.fim = f; bus.fim_jogo = fj;
    @(posedge clock); #1;
    model_step(ins, n, f, fj);
    bus.insere = 1'b0; bus.fim = 1'b0; bus.fim_jogo = 1'b0;
  endtask

  task automatic put(input int n);  cyc(1'b1, n, 1'b0, 1'b0); endtask
  task automatic close_bet();       cyc(1'b0, 0, 1'b1, 1'b0); endtask
  task automatic idle();            cyc(1'b0, 0, 1'b0, 1'b0); endtask

  task automatic bet5(input int a, input int b, input int c, input int d, input int e);
    put(a); put(b); put(c); put(d); put(e); close_bet();
  endtask

  task automatic reset_state_checks(input string tag);
    check({tag, ".aceita"}, bus.aceita, 1);
    check({tag, ".jogador"}, bus.jogador, 0);
    check({tag, ".premio"}, bus.premio, 0);
    check({tag, ".premio_valid"}, bus.premio_valid, 0);
    check({tag, ".pontos"}, bus.pontos, 0);
    check({tag, ".game_over"}, bus.game_over, 0);
    check({tag, ".vencedor"}, bus.vencedor, 0);
    check({tag, ".empate"}, bus.empate, 0);
  endtask

  task automatic release_reset();
    model_reset();
    @(posedge clock); #1;
    reset  = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic fresh_game();
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    reset_state_checks("rst");
    release_reset();
    put(5); put(3); put(8); put(2); put(0);
  endtask

  int sat_exp[4] = '{10, 20, 30, 31};

  initial begin
    bus.numero = '0; bus.insere = 1'b0; bus.fim = 1'b0; bus.fim_jogo = 1'b0;
    model_reset();
    #12;
    fresh_game();

    // 1. exact match
    bet5(5, 3, 8, 2, 0);
    check("t1.valid", bus.premio_valid, 1);
    check("t1.premio", bus.premio, 5);
    idle();
    check("t1.valid_off", bus.premio_valid, 0);
    check("t1.p0", score_of(0), 10);
    check("t1.jog", bus.jogador, 1);

    // 2. three scattered hits, then a run of three
    bet5(5, 1, 8, 1, 0);
    check("t2.premio3", bus.premio, 3);
    idle();
    check("t2.p1", score_of(1), 4);
    bet5(5, 3, 8, 9, 9);
    check("t2.premio4", bus.premio, 4);
    idle();
    check("t2.p0", score_of(0), 16);

    // 3. partial bet closed with insere+fim, then overfull bet
    put(5);
    cyc(1'b1, 3, 1'b1, 1'b0);
    check("t3.premio2", bus.premio, 2);
    idle();
    check("t3.p1", score_of(1), 6);
    put(1); put(1); put(1); put(1); put(1);
    check("t3.full_aceita", bus.aceita, 0);
    put(0);
    close_bet();
    check("t3.premio0", bus.premio, 0);
    idle();
    check("t3.p0", score_of(0), 16);
    cyc(1'b0, 0, 1'b0, 1'b1);
    check("t3.over", bus.game_over, 1);
    check("t3.winner", bus.vencedor, 0);
    check("t3.notie", bus.empate, 0);

    // 4. saturation
    fresh_game();
    for (int r = 0; r < 4; r++) begin
      bet5(5, 3, 8, 2, 0);
      idle();
      check($sformatf("t4.p0[%0d]", r), score_of(0), sat_exp[r]);
      close_bet();
      check("t4.empty_premio", bus.premio, 0);
      idle();
      check("t4.p1", score_of(1), 0);
    end

    // 5. tie at 16/16, inputs ignored afterwards
    fresh_game();
    bet5(5, 3, 8, 2, 0); idle();
    bet5(5, 3, 8, 2, 0); idle();
    bet5(5, 3, 8, 9, 9); idle();
    bet5(5, 3, 8, 9, 9); idle();
    cyc(1'b0, 0, 1'b0, 1'b1);
    check("t5.over", bus.game_over, 1);
    check("t5.winner", bus.vencedor, 0);
    check("t5.tie", bus.empate, 1);
    cyc(1'b1, 5, 1'b0, 1'b0);
    cyc(1'b1, 3, 1'b1, 1'b0);
    idle();
    check("t5.still_over", bus.game_over, 1);
    check("t5.p0", score_of(0), 16);
    check("t5.p1", score_of(1), 16);
    check("t5.aceita", bus.aceita, 0);

    // 6. asynchronous reset between edges, in S_BET and in S_EVAL
    fresh_game();
    bet5(5, 3, 8, 2, 0); idle();
    put(5); put(3);
    chk_en = 1'b0;
    #2 reset = 1'b0;
    #1 reset_state_checks("t6.bet");
    release_reset();
    put(5); put(3); put(8); put(2); put(0);
    bet5(5, 3, 8, 2, 0);
    check("t6.in_eval", bus.premio_valid, 1);
    chk_en = 1'b0;
    #2 reset = 1'b0;
    #1 reset_state_checks("t6.eval");
    release_reset();
    idle();
    check("t6.post_aceita", bus.aceita, 1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
